// File: rtl/cordic_pkg.sv
// Shared types, constants and helpers for the iterative CORDIC engine.
//   mode_e    : operation mode captured with each operand set
//   state_e   : engine FSM states
//   ATAN_Q29  : atan(2^-i) in Q2.29, rounded to nearest, i = 0..31
//   atan_lut  : ATAN_Q29[i] re-rounded to 'frac' fractional bits
package cordic_pkg;

  typedef enum logic {
    ROTATION  = 1'b0,
    VECTORING = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ATAN_FRAC = 29;

  localparam logic [31:0] ATAN_Q29 [0:31] = '{
    32'd421657428, 32'd248918915, 32'd131521918, 32'd66762579,
    32'd33510843,  32'd16771758,  32'd8387925,   32'd4194219,
    32'd2097141,   32'd1048575,   32'd524288,    32'd262144,
    32'd131072,    32'd65536,     32'd32768,     32'd16384,
    32'd8192,      32'd4096,      32'd2048,      32'd1024,
    32'd512,       32'd256,       32'd128,       32'd64,
    32'd32,        32'd16,        32'd8,         32'd4,
    32'd2,         32'd1,         32'd0,         32'd0
  };

  // Round-to-nearest: add half an output LSB, then drop the extra bits.
  // Table entries are non-negative, so a logical shift is equivalent to
  // an arithmetic one here.
  function automatic logic [31:0] atan_lut(input logic [4:0] i, input int frac);
    logic [31:0] v;
    int          sh;
    sh = ATAN_FRAC - frac;
    if (sh <= 0) begin
      v = ATAN_Q29[i] << (-sh);
    end else begin
      v = (ATAN_Q29[i] + (32'd1 << (sh - 1))) >> sh;
    end
    return v;
  endfunction

endpackage

// File: rtl/cordic_micro_rotation.sv
// One combinational CORDIC micro-rotation step.
//   x, y      : current vector (signed, BIT_WIDTH+GUARD bits)
//   z         : current angle accumulator (signed Q3.(BIT_WIDTH-3))
//   i         : iteration index, sets the shift distance
//   mode      : ROTATION drives z toward 0, VECTORING drives y toward 0
//   atan      : atan(2^-i) in the same format as z
//   x_nxt, y_nxt, z_nxt : vector/angle after this step
//   d         : direction decision used for this step
module cordic_micro_rotation
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int GUARD     = 2,
  parameter int CNT_W     = 4
) (
  input  logic signed [BIT_WIDTH+GUARD-1:0] x,
  input  logic signed [BIT_WIDTH+GUARD-1:0] y,
  input  logic signed [BIT_WIDTH-1:0]       z,
  input  logic        [CNT_W-1:0]           i,
  input  mode_e                             mode,
  input  logic signed [BIT_WIDTH-1:0]       atan,
  output logic signed [BIT_WIDTH+GUARD-1:0] x_nxt,
  output logic signed [BIT_WIDTH+GUARD-1:0] y_nxt,
  output logic signed [BIT_WIDTH-1:0]       z_nxt,
  output logic                              d
);

  localparam int XW = BIT_WIDTH + GUARD;

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  assign x_sh = x >>> i;
  assign y_sh = y >>> i;

  // Vectoring: d=1 whenever x and y share a sign (y=0 with x>=0 counts
  // as same sign), which rotates clockwise and pulls y toward zero.
  assign d = (mode == VECTORING) ? ~(x[XW-1] ^ y[XW-1]) : z[BIT_WIDTH-1];

  // Both new coordinates use the pre-step x/y; z wraps modulo 2^BIT_WIDTH.
  always_comb begin
    if (d) begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan;
    end else begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan;
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, K gain not removed.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   in_valid/ready  : operand handshake (x_in, y_in, z_in, mode_bit)
//   out_valid/ready : result handshake (x_out, y_out, z_out, dir_bits)
//   dir_bits        : d_i of each iteration, bit i = iteration i
//   state_dbg       : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE and the
// result holds stable until out_ready is seen. Neither side's valid may
// depend on the other side's ready.
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int ITERATIONS = 12,
  parameter int GUARD      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [BIT_WIDTH-1:0]       x_in,
  input  logic signed [BIT_WIDTH-1:0]       y_in,
  input  logic signed [BIT_WIDTH-1:0]       z_in,
  input  logic                              mode_bit,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [BIT_WIDTH+GUARD-1:0] x_out,
  output logic signed [BIT_WIDTH+GUARD-1:0] y_out,
  output logic signed [BIT_WIDTH-1:0]       z_out,
  output logic        [ITERATIONS-1:0]      dir_bits,
  output state_e                            state_dbg
);

  localparam int XW    = BIT_WIDTH + GUARD;
  localparam int FRAC  = BIT_WIDTH - 3;
  localparam int CNT_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERATIONS - 1);

  state_e                 state;
  state_e                 state_nxt;
  logic                   accept;
  logic                   last;

  logic signed [XW-1:0]        x_r;
  logic signed [XW-1:0]        y_r;
  logic signed [BIT_WIDTH-1:0] z_r;
  mode_e                       mode_r;
  logic [CNT_W-1:0]            iter;
  logic [ITERATIONS-1:0]       dir_r;
  logic [ITERATIONS-1:0]       dir_upd;

  logic signed [XW-1:0]        x_nxt;
  logic signed [XW-1:0]        y_nxt;
  logic signed [BIT_WIDTH-1:0] z_nxt;
  logic                        d;
  logic signed [BIT_WIDTH-1:0] atan_val;

  assign state_dbg = state;
  assign atan_val  = BIT_WIDTH'(atan_lut(5'(iter), FRAC));

  cordic_micro_rotation #(
    .BIT_WIDTH (BIT_WIDTH),
    .GUARD     (GUARD),
    .CNT_W     (CNT_W)
  ) u_step (
    .x     (x_r),
    .y     (y_r),
    .z     (z_r),
    .i     (iter),
    .mode  (mode_r),
    .atan  (atan_val),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt),
    .d     (d)
  );

  // Direction history including the step being taken this cycle, so the
  // final iteration's bit reaches dir_bits on the RUN->DONE edge.
  always_comb begin
    dir_upd       = dir_r;
    dir_upd[iter] = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (iter == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers advance every RUN cycle; the visible result only
  // changes on the final iteration so it stays stable through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      mode_r   <= ROTATION;
      iter     <= '0;
      dir_r    <= '0;
      x_out    <= '0;
      y_out    <= '0;
      z_out    <= '0;
      dir_bits <= '0;
    end else if (accept) begin
      x_r    <= XW'(x_in);
      y_r    <= XW'(y_in);
      z_r    <= z_in;
      mode_r <= mode_e'(mode_bit);
      iter   <= '0;
      dir_r  <= '0;
    end else if (state == RUN) begin
      x_r   <= x_nxt;
      y_r   <= y_nxt;
      z_r   <= z_nxt;
      dir_r <= dir_upd;
      if (last) begin
        iter     <= '0;
        x_out    <= x_nxt;
        y_out    <= y_nxt;
        z_out    <= z_nxt;
        dir_bits <= dir_upd;
      end else begin
        iter <= iter + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine: a golden CORDIC model fills
// an expected queue at stimulus time, a monitor pops and compares on each
// result handshake, directed steps check latency, reset, backpressure and
// throughput.
module tb_cordic_iter_engine;
  import cordic_pkg::*;

  localparam int BW = 16;
  localparam int IT = 12;
  localparam int GD = 2;
  localparam int XW = BW + GD;
  localparam int EW = XW + XW + BW + IT;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [BW-1:0] x_in;
  logic signed [BW-1:0] y_in;
  logic signed [BW-1:0] z_in;
  logic                 mode_bit;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [XW-1:0] x_out;
  logic signed [XW-1:0] y_out;
  logic signed [BW-1:0] z_out;
  logic [IT-1:0]        dir_bits;
  state_e               state_dbg;

  cordic_iter_engine #(
    .BIT_WIDTH  (BW),
    .ITERATIONS (IT),
    .GUARD      (GD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .mode_bit  (mode_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .dir_bits  (dir_bits),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  int cyc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- golden model ----------------
  int atan_tab [0:IT-1];

  function automatic logic [EW-1:0] model(input logic signed [BW-1:0] xi,
                                          input logic signed [BW-1:0] yi,
                                          input logic signed [BW-1:0] zi,
                                          input logic m);
    logic signed [XW-1:0] x, y, xn, yn;
    logic signed [BW-1:0] z, a;
    logic [IT-1:0]        dir;
    logic                 dd;
    x = xi;
    y = yi;
    z = zi;
    dir = '0;
    for (int i = 0; i < IT; i++) begin
      a  = 16'(atan_tab[i]);
      dd = m ? (x[XW-1] == y[XW-1]) : z[BW-1];
      if (dd) begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
        z  = z + a;
      end else begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
        z  = z - a;
      end
      dir[i] = dd;
      x = xn;
      y = yn;
    end
    return {x, y, z, dir};
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0]        exp_q[$];
  logic [EW-1:0]        mon_e;
  logic signed [XW-1:0] ex_x, ex_y;
  logic signed [BW-1:0] ex_z;
  logic [IT-1:0]        ex_d;
  logic signed [XW-1:0] last_x, last_y;
  logic signed [BW-1:0] last_z;
  logic [IT-1:0]        last_dir;
  int                   res_cnt;
  int                   exp_res;

  initial begin
    res_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        check("sb_nonempty", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          {ex_x, ex_y, ex_z, ex_d} = mon_e;
          check("sb_x", x_out, ex_x);
          check("sb_y", y_out, ex_y);
          check("sb_z", z_out, ex_z);
          check("sb_dir", dir_bits, ex_d);
        end
        last_x   = x_out;
        last_y   = y_out;
        last_z   = z_out;
        last_dir = dir_bits;
        res_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int accept_cyc;

  task automatic send(input logic signed [BW-1:0] xv, input logic signed [BW-1:0] yv,
                      input logic signed [BW-1:0] zv, input logic m);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("send_in_ready", longint'(in_ready), 1);
    x_in     = xv;
    y_in     = yv;
    z_in     = zv;
    mode_bit = m;
    in_valid = 1'b1;
    exp_q.push_back(model(xv, yv, zv, m));
    exp_res++;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid   = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, cyc - accept_cyc, IT);
  endtask

  task automatic wait_results();
    int n;
    n = 0;
    while (res_cnt < exp_res && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("result_count", res_cnt, exp_res);
  endtask

  function automatic logic signed [BW-1:0] rnd_s(input int lo, input int hi);
    return BW'(int'($urandom_range(0, hi - lo)) + lo);
  endfunction

  // ---------------- main sequence ----------------
  logic signed [XW-1:0] snap_x;
  logic [IT-1:0]        snap_d;
  int                   a1;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_res   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_in      = '0;
    y_in      = '0;
    z_in      = '0;
    mode_bit  = 1'b0;
    for (int i = 0; i < IT; i++) begin
      atan_tab[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 8192.0 + 0.5);
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    check("rst_z_out", z_out, 0);
    check("rst_dir", dir_bits, 0);
    check("rst_state", state_dbg, IDLE);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // rotation of (4096, 0) by 0 rad
    send(16'sd4096, 16'sd0, 16'sd0, 1'b0);
    wait_valid("t2_latency");
    wait_results();
    check("t2_dir0", last_dir[0], 0);
    check("t2_x_tol", longint'(last_x >= 6741 && last_x <= 6749), 1);
    check("t2_y_tol", longint'(last_y >= -4 && last_y <= 4), 1);
    check("t2_z_tol", longint'(last_z >= -4 && last_z <= 4), 1);

    // reset in the middle of RUN
    send(rnd_s(-20000, 20000), rnd_s(-20000, 20000), rnd_s(-12000, 12000), 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("t1_state_run", state_dbg, RUN);
    rst = 1'b1;
    #1;
    check("t1_out_valid", out_valid, 0);
    check("t1_in_ready", in_ready, 1);
    check("t1_x_out", x_out, 0);
    check("t1_y_out", y_out, 0);
    check("t1_z_out", z_out, 0);
    check("t1_dir", dir_bits, 0);
    exp_q.delete();
    exp_res--;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(rnd_s(-20000, 20000), rnd_s(-20000, 20000), rnd_s(-12000, 12000), 1'b0);
    wait_valid("t1_latency");
    wait_results();

    // rotation sign check: z = -1
    send(16'sd4096, 16'sd0, -16'sd1, 1'b0);
    @(posedge clk);
    #1;
    check("t3_y_it0", dut.y_r, -4096);
    check("t3_z_it0", dut.z_r, 6433);
    wait_results();
    check("t3_dir0", last_dir[0], 1);

    // vectoring of (4096, 4096)
    send(16'sd4096, 16'sd4096, 16'sd0, 1'b1);
    @(posedge clk);
    #1;
    check("t4_x_it0", dut.x_r, 8192);
    check("t4_y_it0", dut.y_r, 0);
    wait_results();
    check("t4_dir0", last_dir[0], 1);
    check("t4_z_tol", longint'(last_z >= 6422 && last_z <= 6446), 1);
    check("t4_x_tol", longint'(last_x >= 9532 && last_x <= 9548), 1);
    check("t4_y_tol", longint'(last_y >= -4 && last_y <= 4), 1);

    // backpressure in DONE
    out_ready = 1'b0;
    send(rnd_s(-20000, 20000), rnd_s(-20000, 20000), rnd_s(-12000, 12000), 1'b0);
    wait_valid("t5_latency");
    @(posedge clk);
    #1;
    snap_x = x_out;
    snap_d = dir_bits;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        x_in     = 16'sd1234;
        y_in     = -16'sd777;
        z_in     = 16'sd100;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("t5_out_valid", out_valid, 1);
      check("t5_in_ready", in_ready, 0);
      check("t5_x_stable", x_out, snap_x);
      check("t5_dir_stable", dir_bits, snap_d);
    end
    out_ready = 1'b1;
    wait_results();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t5_idle_after", state_dbg, IDLE);
    check("t5_no_capture", out_valid, 0);

    // back-to-back throughput
    send(rnd_s(-20000, 20000), rnd_s(-20000, 20000), rnd_s(-12000, 12000), 1'b0);
    a1 = accept_cyc;
    send(16'(int'($urandom_range(1000, 20000))), rnd_s(-20000, 20000), 16'sd0, 1'b1);
    check("t6_period", accept_cyc - a1, IT + 2);
    wait_results();

    // random mix
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        send(16'(int'($urandom_range(1000, 20000))), rnd_s(-20000, 20000),
             rnd_s(-2000, 2000), 1'b1);
      end else begin
        send(rnd_s(-20000, 20000), rnd_s(-20000, 20000), rnd_s(-12000, 12000), 1'b0);
      end
    end
    wait_results();
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
